// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: monitors a multiplexed 8-digit seven-segment bus and keeps a decoded shadow of the display
module seg_scan_decoder #(
    parameter int SETTLE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  an,
    input  logic [7:0]  seg,
    input  logic        clr_err,
    output logic [31:0] hex,
    output logic [7:0]  dp,
    output logic [7:0]  valid,
    output logic [7:0]  blank,
    output logic        upd,
    output logic [2:0]  upd_idx,
    output logic        frame_done,
    output logic        err_code,
    output logic        err_an
);
    localparam logic [7:0] SET = 8'(SETTLE);
    localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [7:0] prevAn, prevSeg, count, nextCount, seen, seenNext;
    logic       oneHot, same, capture, hit;
    logic [2:0] idx;
    logic [3:0] val;
    logic [6:0] lit;

    // qualify the sample, advance the stability count and decode the lit pattern
    always_comb begin
        oneHot = an != 8'hFF && (((~an) & ((~an) - 8'd1)) == 8'h00);
        same = {an, seg} == {prevAn, prevSeg};
        nextCount = !oneHot ? 8'd0 : !same ? 8'd1 : count >= SET ? SET : count + 8'd1;
        capture = oneHot && nextCount == SET && !(same && count == SET);
        idx = 3'd0;
        for (int i = 0; i < 8; i++) if (!an[i]) idx = 3'(i);
        lit = ~seg[6:0];
        hit = 1'b0;
        val = 4'd0;
        for (int i = 0; i < 16; i++) if (lit == GLYPH[i]) begin hit = 1'b1; val = 4'(i); end
        seenNext = seen | (8'd1 << idx);
    end

    // sample history, capture into the shadow, frame tracking and sticky errors
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prevAn     <= 8'hFF;
            prevSeg    <= 8'hFF;
            count      <= 8'd0;
            seen       <= 8'd0;
            hex        <= 32'd0;
            dp         <= 8'd0;
            valid      <= 8'd0;
            blank      <= 8'd0;
            upd        <= 1'b0;
            upd_idx    <= 3'd0;
            frame_done <= 1'b0;
            err_code   <= 1'b0;
            err_an     <= 1'b0;
        end else begin
            prevAn     <= an;
            prevSeg    <= seg;
            count      <= nextCount;
            upd        <= capture;
            upd_idx    <= idx;
            frame_done <= capture && seenNext == 8'hFF;
            if (capture) begin
                seen       <= seenNext == 8'hFF ? 8'h00 : seenNext;
                dp[idx]    <= ~seg[7];
                valid[idx] <= hit;
                blank[idx] <= lit == 7'h00;
                if (hit) hex[{idx, 2'b00} +: 4] <= val;
            end
            err_code <= (capture && !hit && lit != 7'h00) || (err_code && !clr_err);
            err_an   <= (an != 8'hFF && !oneHot) || (err_an && !clr_err);
        end
    end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: randomized and directed checks of seg_scan_decoder against a run-length display model
module tb_seg_scan_decoder;
    localparam int SETTLE = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  an = 8'hFF, seg = 8'hFF;
    logic        clr_err = 1'b0;
    logic [31:0] hex;
    logic [7:0]  dp, valid, blank;
    logic        upd, frame_done, err_code, err_an;
    logic [2:0]  upd_idx;

    int nChecks = 0, nFail = 0, updCnt = 0, fdCnt = 0;
    int glyph [16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                       'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};
    logic [3:0]  mHex [8];
    logic [7:0]  mDp, mValid, mBlank, mSeen;
    logic        mErrCode, mErrAn, eUpd, eFd;
    logic [2:0]  eIdx;
    logic [15:0] prevSmp;
    int          runLen;

    seg_scan_decoder #(.SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .an(an), .seg(seg), .clr_err(clr_err),
        .hex(hex), .dp(dp), .valid(valid), .blank(blank), .upd(upd), .upd_idx(upd_idx),
        .frame_done(frame_done), .err_code(err_code), .err_an(err_an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] packHex();
        logic [31:0] r = 32'd0;
        for (int k = 0; k < 8; k++) r[k*4 +: 4] = mHex[k];
        return r;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 8; k++) mHex[k] = 4'd0;
        {mDp, mValid, mBlank, mSeen} = '0;
        {mErrCode, mErrAn, eUpd, eFd} = '0;
        eIdx = 3'd0;
        prevSmp = 16'hFFFF;
        runLen = 0;
    endtask

    task automatic modelEdge(input logic [7:0] a, input logic [7:0] s, input logic c);
        int ones, found, d;
        logic [6:0] lit;
        ones = $countones(~a);
        eUpd = 1'b0;
        eFd = 1'b0;
        if (c) begin mErrCode = 1'b0; mErrAn = 1'b0; end
        if (ones >= 2) mErrAn = 1'b1;
        runLen = ones != 1 ? 0 : {a, s} == prevSmp ? runLen + 1 : 1;
        prevSmp = {a, s};
        if (runLen == SETTLE) begin
            d = 0;
            for (int k = 0; k < 8; k++) if (!a[k]) d = k;
            lit = ~s[6:0];
            found = -1;
            for (int k = 0; k < 16; k++) if (glyph[k] == int'(lit)) found = k;
            eUpd = 1'b1;
            eIdx = 3'(d);
            mDp[d] = ~s[7];
            mValid[d] = found >= 0;
            mBlank[d] = lit == 7'h00;
            if (found >= 0) mHex[d] = 4'(found);
            else if (lit != 7'h00) mErrCode = 1'b1;
            mSeen[d] = 1'b1;
            if (mSeen == 8'hFF) begin eFd = 1'b1; mSeen = 8'h00; end
        end
    endtask

    task automatic checkOutputs();
        check("upd", upd, eUpd);
        if (eUpd) check("upd_idx", upd_idx, eIdx);
        check("frame_done", frame_done, eFd);
        check("hex", hex, packHex());
        check("dp", dp, mDp);
        check("valid", valid, mValid);
        check("blank", blank, mBlank);
        check("err_code", err_code, mErrCode);
        check("err_an", err_an, mErrAn);
    endtask

    task automatic cycle(input logic [7:0] a, input logic [7:0] s, input logic c);
        an = a;
        seg = s;
        clr_err = c;
        @(posedge clk);
        modelEdge(a, s, c);
        #1;
        checkOutputs();
        updCnt += int'(upd);
        fdCnt += int'(frame_done);
    endtask

    task automatic doReset();
        rst = 1'b1;
        #1;
        modelReset();
        checkOutputs();
        check("rst_upd_idx", upd_idx, 3'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] a, s;
        int len;
        repeat (2) @(posedge clk);
        #1;
        doReset();

        updCnt = 0;
        for (int k = 0; k < 6; k++) begin
            cycle(8'hFE, 8'hC0, 1'b0);
            if (k == 3) check("first_cap_edge4", upd, 1'b1);
        end
        check("first_cap_once", updCnt, 1);
        check("first_hex0", hex[3:0], 4'h0);
        check("first_valid0", valid[0], 1'b1);
        check("first_dp0", dp[0], 1'b0);

        updCnt = 0;
        repeat (3) cycle(8'hDF, 8'h08, 1'b0);
        check("restart_nocap", updCnt, 0);
        repeat (4) cycle(8'hDF, 8'h88, 1'b0);
        check("restart_idx", upd_idx, 3'd5);
        check("restart_hex5", hex[23:20], 4'hA);
        check("restart_dp5", dp[5], 1'b0);

        fdCnt = 0;
        for (int d = 0; d < 8; d++) begin
            s = {(d == 3) ? 1'b0 : 1'b1, ~7'(glyph[d + 1])};
            a = ~(8'd1 << d);
            repeat (5) cycle(a, s, 1'b0);
        end
        check("scan_frame_once", fdCnt, 1);
        check("scan_hex", hex, 32'h87654321);
        check("scan_dp", dp, 8'h08);
        check("scan_valid", valid, 8'hFF);

        cycle(8'hFF, 8'hFF, 1'b0);
        updCnt = 0;
        repeat (10) cycle(8'hFC, 8'hC0, 1'b0);
        check("multi_err_an", err_an, 1'b1);
        check("multi_noupd", updCnt, 0);
        cycle(8'hFF, 8'hFF, 1'b1);
        check("clr_err_an", err_an, 1'b0);
        repeat (5) cycle(8'hF7, 8'hFF, 1'b0);
        check("blank3", blank[3], 1'b1);
        check("blank_valid3", valid[3], 1'b0);
        check("blank_no_err", err_code, 1'b0);

        repeat (5) cycle(8'hBF, 8'hF6, 1'b0);
        check("bad_err_code", err_code, 1'b1);
        check("bad_valid6", valid[6], 1'b0);
        check("bad_hex6_kept", hex[27:24], 4'h7);

        repeat (2) cycle(8'hEF, 8'hB0, 1'b0);
        doReset();
        check("rst_hex_zero", hex, 32'd0);
        updCnt = 0;
        repeat (3) cycle(8'hEF, 8'hB0, 1'b0);
        check("rst_fresh_nocap", updCnt, 0);
        cycle(8'hEF, 8'hB0, 1'b0);
        check("rst_fresh_cap", upd, 1'b1);

        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0: a = 8'hFF;
                1: a = 8'($urandom);
                default: a = ~(8'd1 << $urandom_range(0, 7));
            endcase
            s = ($urandom_range(0, 4) == 0) ? 8'($urandom)
                : {1'($urandom), ~7'(glyph[$urandom_range(0, 15)])};
            len = $urandom_range(1, 7);
            repeat (len) cycle(a, s, $urandom_range(0, 19) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
